// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: debounces board inputs and runs the RUN/PAUSED/ADJUST FSM.
// Latency: raw input step -> outputs in DEB_CYCLES+3 cycles; no backpressure (free-running).
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic       refreshClock,
    input  logic       reset,
    input  logic       btnPause,
    input  logic       btnClear,
    input  logic       swAdj,
    input  logic [1:0] swSel,
    input  logic       twoHz,
    output logic       isPaused,
    output logic       isAdj,
    output logic [1:0] select,
    output logic       clear,
    output logic [3:0] blinkMask,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        PAUSED = 2'b01,
        ADJUST = 2'b10
    } mode_t;

    localparam int              NIN      = 5;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    mode_t            curState, nextState;
    logic [NIN-1:0]   rawVec, sync1, sync2, debLvl, debQ;
    logic [CNT_W-1:0] debCnt [NIN];
    logic             pressP, pressC;
    logic             adjLvl;
    logic [1:0]       selLvl;
    logic [2:0]       twoSh;
    logic             blinkRise;
    logic             phase, phaseNext;
    logic [1:0]       selNext;

    // bit order: {swSel[1:0], swAdj, btnClear, btnPause}
    assign rawVec = {swSel, swAdj, btnClear, btnPause};

    always_ff @(posedge refreshClock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= rawVec;
            sync2 <= sync1;
        end
    end

    // Level is accepted on the cycle the mismatch count would reach DEB_CYCLES.
    always_ff @(posedge refreshClock or posedge reset) begin
        if (reset) begin
            debLvl <= '0;
            for (int i = 0; i < NIN; i++) debCnt[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == debLvl[i]) begin
                    debCnt[i] <= '0;
                end else if (debCnt[i] == DEB_LAST) begin
                    debLvl[i] <= sync2[i];
                    debCnt[i] <= '0;
                end else begin
                    debCnt[i] <= debCnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Registered edge stage: strobes and levels all reach the FSM with equal latency.
    always_ff @(posedge refreshClock or posedge reset) begin
        if (reset) begin
            debQ   <= '0;
            pressP <= 1'b0;
            pressC <= 1'b0;
            clear  <= 1'b0;
            twoSh  <= '0;
        end else begin
            debQ   <= debLvl;
            pressP <= debLvl[0] & ~debQ[0];
            pressC <= debLvl[1] & ~debQ[1];
            clear  <= pressC;
            twoSh  <= {twoSh[1:0], twoHz};
        end
    end

    assign adjLvl    = debQ[2];
    assign selLvl    = debQ[4:3];
    assign blinkRise = twoSh[1] & ~twoSh[2];

    always_ff @(posedge refreshClock or posedge reset) begin
        if (reset) begin
            curState <= PAUSED;
            select   <= 2'd0;
            phase    <= 1'b0;
        end else begin
            curState <= nextState;
            select   <= selNext;
            phase    <= phaseNext;
        end
    end

    always_comb begin
        nextState = curState;
        selNext   = select;
        phaseNext = phase;
        if (adjLvl && curState != ADJUST) begin
            nextState = ADJUST;
            phaseNext = 1'b0;
            selNext   = selLvl;
        end else if (!adjLvl && curState == ADJUST) begin
            nextState = PAUSED;
        end else if (curState == ADJUST) begin
            selNext = selLvl;
            if (blinkRise) phaseNext = ~phase;
        end else if (pressP) begin
            nextState = (curState == RUN) ? PAUSED : RUN;
        end
    end

    assign state     = curState;
    assign isPaused  = (curState == PAUSED);
    assign isAdj     = (curState == ADJUST);
    assign blinkMask = (isAdj && phase) ? (4'b0001 << select) : 4'b0000;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES=4; expected values are hand-computed.
module tb_stopwatch_ctrl;

    logic       refreshClock = 1'b0;
    logic       reset;
    logic       btnPause, btnClear, swAdj, twoHz;
    logic [1:0] swSel;
    logic       isPaused, isAdj, clear;
    logic [1:0] select, state;
    logic [3:0] blinkMask;

    int nTests = 0;
    int nFail  = 0;

    stopwatch_ctrl #(.DEB_CYCLES(4), .CNT_W(4)) dut (
        .refreshClock(refreshClock),
        .reset(reset),
        .btnPause(btnPause),
        .btnClear(btnClear),
        .swAdj(swAdj),
        .swSel(swSel),
        .twoHz(twoHz),
        .isPaused(isPaused),
        .isAdj(isAdj),
        .select(select),
        .clear(clear),
        .blinkMask(blinkMask),
        .state(state)
    );

    always #5 refreshClock = ~refreshClock;

    task automatic checkVal(input string tag, input int got, input int exp);
        nTests++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge refreshClock);
        #1;
    endtask

    task automatic pressPause();
        btnPause = 1'b1;
        step(12);
        btnPause = 1'b0;
        step(10);
    endtask

    // Hold btnClear, count clear pulses and note the edge index of the first one.
    task automatic watchClear(output int pulses, output int firstAt);
        pulses  = 0;
        firstAt = 0;
        btnClear = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            if (i == 15) btnClear = 1'b0;
            step(1);
            if (clear) begin
                pulses++;
                if (firstAt == 0) firstAt = i;
            end
        end
    endtask

    initial begin
        int firstAt, trans, pulses;
        logic [1:0] prev;

        reset = 1'b1; btnPause = 0; btnClear = 0; swAdj = 0; swSel = 2'b00; twoHz = 0;
        step(3);
        checkVal("rst_state", int'(state), 1);
        checkVal("rst_isPaused", int'(isPaused), 1);
        checkVal("rst_isAdj", int'(isAdj), 0);
        checkVal("rst_select", int'(select), 0);
        checkVal("rst_clear", int'(clear), 0);
        checkVal("rst_blink", int'(blinkMask), 0);
        reset = 1'b0;
        step(2);

        // 1: held pause button -> RUN after 4+3 edges past the first sampling edge
        btnPause = 1'b1;
        prev = state; trans = 0; firstAt = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (state != prev) begin
                trans++;
                if (firstAt == 0) firstAt = i;
            end
            prev = state;
        end
        checkVal("t1_latency", firstAt, 8);
        checkVal("t1_transitions", trans, 1);
        checkVal("t1_state", int'(state), 0);
        checkVal("t1_isPaused", int'(isPaused), 0);
        btnPause = 1'b0;
        step(10);

        // 2: 3-cycle glitch is filtered
        btnPause = 1'b1;
        step(3);
        btnPause = 1'b0;
        step(12);
        checkVal("t2_state", int'(state), 0);
        checkVal("t2_isPaused", int'(isPaused), 0);

        // 3: clear pulse in RUN, then in PAUSED
        watchClear(pulses, firstAt);
        checkVal("t3_run_pulses", pulses, 1);
        checkVal("t3_run_latency", firstAt, 8);
        checkVal("t3_run_state", int'(state), 0);
        pressPause();
        checkVal("t3_to_paused", int'(state), 1);
        watchClear(pulses, firstAt);
        checkVal("t3_pau_pulses", pulses, 1);
        checkVal("t3_pau_state", int'(state), 1);

        // 4: adjust mode with select=2 and blink
        swSel = 2'b10;
        step(10);
        checkVal("t4_sel_frozen", int'(select), 0);
        swAdj = 1'b1;
        step(10);
        checkVal("t4_state", int'(state), 2);
        checkVal("t4_isAdj", int'(isAdj), 1);
        checkVal("t4_isPaused", int'(isPaused), 0);
        checkVal("t4_select", int'(select), 2);
        checkVal("t4_blink0", int'(blinkMask), 0);
        twoHz = 1'b1; step(4);
        checkVal("t4_blink1", int'(blinkMask), 4);
        twoHz = 1'b0; step(4);
        twoHz = 1'b1; step(4);
        checkVal("t4_blink2", int'(blinkMask), 0);
        twoHz = 1'b0; step(4);
        twoHz = 1'b1; step(4);
        checkVal("t4_blink3", int'(blinkMask), 4);
        twoHz = 1'b0; step(4);
        checkVal("t4_fall_hold", int'(blinkMask), 4);
        swAdj = 1'b0;
        step(10);
        checkVal("t4_exit_state", int'(state), 1);
        checkVal("t4_exit_blink", int'(blinkMask), 0);
        checkVal("t4_exit_select", int'(select), 2);

        // 5: pause ignored in ADJUST; select change moves mask, phase kept
        swAdj = 1'b1;
        step(10);
        checkVal("t5_enter_blink", int'(blinkMask), 0);
        twoHz = 1'b1; step(4);
        checkVal("t5_blink", int'(blinkMask), 4);
        pressPause();
        checkVal("t5_pause_ign", int'(state), 2);
        swSel = 2'b01;
        step(10);
        checkVal("t5_select", int'(select), 1);
        checkVal("t5_mask_move", int'(blinkMask), 2);
        swAdj = 1'b0;
        step(10);
        checkVal("t5_exit", int'(state), 1);
        pressPause();
        checkVal("t5_run", int'(state), 0);

        // 6: simultaneous pause+adjust from RUN, then reset during a clear debounce
        btnPause = 1'b1;
        swAdj    = 1'b1;
        step(10);
        checkVal("t6_adj_wins", int'(state), 2);
        checkVal("t6_select", int'(select), 1);
        btnClear = 1'b1;
        step(4);
        checkVal("t6_pre_clear", int'(clear), 0);
        reset = 1'b1;
        #1;
        checkVal("t6_rst_state", int'(state), 1);
        checkVal("t6_rst_select", int'(select), 0);
        checkVal("t6_rst_isAdj", int'(isAdj), 0);
        checkVal("t6_rst_blink", int'(blinkMask), 0);
        btnPause = 0; btnClear = 0; swAdj = 0; swSel = 2'b00; twoHz = 0;
        step(3);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (clear) pulses++;
        end
        checkVal("t6_no_clear", pulses, 0);
        checkVal("t6_final_state", int'(state), 1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
